// File: rtl/scr1_axi_pkg.sv
// Shared types and AXI encodings for the single-outstanding core-to-AXI bridge.
package scr1_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_R,
        ST_WR_AW,
        ST_WR_B,
        ST_ERR
    } axi_state_e;

    typedef enum logic [1:0] {
        CW_BYTE  = 2'd0,
        CW_HALF  = 2'd1,
        CW_WORD  = 2'd2,
        CW_DWORD = 2'd3
    } core_width_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    function automatic logic [31:0] width_bytes(input core_width_e width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/scr1_axi_lane_align.sv
// Byte-lane placement for write data/strobes and lane extraction/masking for read data.
module scr1_axi_lane_align
    import scr1_axi_pkg::*;
#(
    parameter int W_DATA = 64,
    parameter int LANE_W = $clog2(W_DATA / 8)
) (
    input  core_width_e         width,
    input  logic [LANE_W-1:0]   lane,
    input  logic [W_DATA-1:0]   wdata_in,
    output logic [W_DATA-1:0]   wdata_out,
    output logic [W_DATA/8-1:0] wstrb,
    input  logic [W_DATA-1:0]   rdata_in,
    output logic [W_DATA-1:0]   rdata_out
);

    localparam int unsigned N_BYTES = W_DATA / 8;

    logic [N_BYTES-1:0] byte_en;
    logic [W_DATA-1:0]  data_mask;
    logic [LANE_W+2:0]  shamt;

    always_comb begin
        byte_en   = '0;
        data_mask = '0;
        for (int unsigned i = 0; i < N_BYTES; i++) begin
            byte_en[i]          = (i < width_bytes(width));
            data_mask[8*i +: 8] = {8{byte_en[i]}};
        end
        shamt     = {lane, 3'b000};
        wstrb     = byte_en << lane;
        wdata_out = wdata_in << shamt;
        rdata_out = (rdata_in >> shamt) & data_mask;
    end

endmodule

// File: rtl/scr1_axi_master_bridge.sv
// Converts the core memory request port into single-beat AXI4 read/write transactions.
module scr1_axi_master_bridge
    import scr1_axi_pkg::*;
#(
    parameter int W_ID   = 4,
    parameter int W_ADR  = 32,
    parameter int W_DATA = 64,
    parameter int AXI_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_cmd,
    input  logic [1:0]          core_width,
    input  logic [W_ADR-1:0]    core_addr,
    input  logic [W_DATA-1:0]   core_wdata,
    output logic                core_ack,
    output logic                core_resp_valid,
    output logic                core_resp_err,
    output logic [W_DATA-1:0]   core_rdata,
    output logic                awvalid,
    output logic [W_ID-1:0]     awid,
    output logic [W_ADR-1:0]    awaddr,
    output logic [2:0]          awsize,
    output logic [7:0]          awlen,
    output logic [1:0]          awburst,
    input  logic                awready,
    output logic                wvalid,
    output logic [W_DATA-1:0]   wdata,
    output logic [W_DATA/8-1:0] wstrb,
    output logic                wlast,
    input  logic                wready,
    input  logic                bvalid,
    input  logic [W_ID-1:0]     bid,
    input  logic [1:0]          bresp,
    output logic                bready,
    output logic                arvalid,
    output logic [W_ID-1:0]     arid,
    output logic [W_ADR-1:0]    araddr,
    output logic [2:0]          arsize,
    output logic [7:0]          arlen,
    output logic [1:0]          arburst,
    input  logic                arready,
    input  logic                rvalid,
    input  logic [W_ID-1:0]     rid,
    input  logic [W_DATA-1:0]   rdata,
    input  logic                rlast,
    input  logic [1:0]          rresp,
    output logic                rready
);

    localparam int N_BYTES = W_DATA / 8;
    localparam int LANE_W  = $clog2(N_BYTES);

    axi_state_e        state_q, state_d;
    logic              cmd_q, cmd_d;
    core_width_e       width_q, width_d;
    logic [W_ADR-1:0]  addr_q, addr_d;
    logic [W_DATA-1:0] wdata_q, wdata_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [W_DATA-1:0] rdata_q, rdata_d;

    logic [31:0]       req_size;
    logic              req_bad;
    logic [W_DATA-1:0] rdata_ext;

    // Request is rejected when misaligned to its size or wider than the data bus.
    always_comb begin
        req_size = width_bytes(core_width_e'(core_width));
        req_bad  = (req_size > 32'(N_BYTES))
                 | ((32'(core_addr[LANE_W-1:0]) & (req_size - 32'd1)) != 32'd0);
    end

    scr1_axi_lane_align #(
        .W_DATA (W_DATA),
        .LANE_W (LANE_W)
    ) u_lane_align (
        .width     (width_q),
        .lane      (addr_q[LANE_W-1:0]),
        .wdata_in  (wdata_q),
        .wdata_out (wdata),
        .wstrb     (wstrb),
        .rdata_in  (rdata),
        .rdata_out (rdata_ext)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        width_d      = width_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;
        core_ack     = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (core_req) begin
                    core_ack  = 1'b1;
                    cmd_d     = core_cmd;
                    width_d   = core_width_e'(core_width);
                    addr_d    = core_addr;
                    wdata_d   = core_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else if (core_cmd) begin
                        state_d = ST_WR_AW;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_RD_R;
                end
            end
            ST_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = (rresp != AXI_RESP_OKAY) | (rid != W_ID'(AXI_ID)) | ~rlast;
                    rdata_d      = rdata_ext;
                end
            end
            ST_WR_AW: begin
                // AW and W complete independently; each valid drops once its own handshake is seen.
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_B;
                end
            end
            ST_WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = (bresp != AXI_RESP_OKAY) | (bid != W_ID'(AXI_ID));
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 1'b0;
            width_q      <= CW_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            width_q      <= width_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign core_resp_valid = resp_valid_q | (state_q == ST_ERR);
    assign core_resp_err   = resp_err_q | (state_q == ST_ERR);
    assign core_rdata      = rdata_q;

    assign awid    = W_ID'(AXI_ID);
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, width_q};
    assign awlen   = 8'd0;
    assign awburst = AXI_BURST_INCR;
    assign wlast   = 1'b1;

    assign arid    = W_ID'(AXI_ID);
    assign araddr  = addr_q;
    assign arsize  = {1'b0, width_q};
    assign arlen   = 8'd0;
    assign arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_scr1_axi_master_bridge.sv
// Directed and randomized checks of the bridge against a byte-addressed memory model and AXI slave.
module tb_scr1_axi_master_bridge;

    localparam int W_ID   = 4;
    localparam int W_ADR  = 32;
    localparam int W_DATA = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req, core_cmd;
    logic [1:0]        core_width;
    logic [W_ADR-1:0]  core_addr;
    logic [W_DATA-1:0] core_wdata;
    logic              core_ack, core_resp_valid, core_resp_err;
    logic [W_DATA-1:0] core_rdata;
    logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic [W_ID-1:0]   awid, bid, arid, rid;
    logic [W_ADR-1:0]  awaddr, araddr;
    logic [2:0]        awsize, arsize;
    logic [7:0]        awlen, arlen, wstrb;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic [W_DATA-1:0] wdata, rdata;

    int n_tests = 0;
    int n_fail  = 0;

    scr1_axi_master_bridge #(
        .W_ID   (W_ID),
        .W_ADR  (W_ADR),
        .W_DATA (W_DATA),
        .AXI_ID (0)
    ) dut (
        .clk (clk), .rst (rst),
        .core_req (core_req), .core_cmd (core_cmd), .core_width (core_width),
        .core_addr (core_addr), .core_wdata (core_wdata), .core_ack (core_ack),
        .core_resp_valid (core_resp_valid), .core_resp_err (core_resp_err), .core_rdata (core_rdata),
        .awvalid (awvalid), .awid (awid), .awaddr (awaddr), .awsize (awsize), .awlen (awlen),
        .awburst (awburst), .awready (awready),
        .wvalid (wvalid), .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wready (wready),
        .bvalid (bvalid), .bid (bid), .bresp (bresp), .bready (bready),
        .arvalid (arvalid), .arid (arid), .araddr (araddr), .arsize (arsize), .arlen (arlen),
        .arburst (arburst), .arready (arready),
        .rvalid (rvalid), .rid (rid), .rdata (rdata), .rlast (rlast), .rresp (rresp), .rready (rready)
    );

    always #5 clk = ~clk;

    // slave configuration
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    logic [3:0] rid_cfg = 4'd0, bid_cfg = 4'd0;
    logic       rlast_cfg = 1'b1;

    // slave state and observations
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, b_wait = 0;
    bit          aw_got = 0, w_got = 0, r_pend = 0, b_pend = 0;
    bit          aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [31:0] h_awaddr, h_araddr;
    logic [63:0] h_wdata;
    logic [7:0]  h_wstrb;
    logic [31:0] cap_awaddr = '0, cap_araddr = '0;
    logic [2:0]  cap_awsize = '0, cap_arsize = '0;
    logic [63:0] cap_wdata = '0;
    logic [7:0]  cap_wstrb = '0, cap_awlen = '0, cap_arlen = '0;
    logic [1:0]  cap_awburst = '0, cap_arburst = '0;
    logic        cap_wlast = 1'b0;
    logic [3:0]  cap_awid = '0, cap_arid = '0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, rready_cyc = 0, proto_viol = 0;

    bit [7:0] smem [4096];
    bit [7:0] rmem [4096];
    logic [63:0] exp_rdata = '0;

    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bid = '0; bresp = '0; rid = '0; rresp = '0; rlast = 0; rdata = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                aw_got = 0; w_got = 0; r_pend = 0; b_pend = 0;
                aw_hold = 0; w_hold = 0; ar_hold = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; b_wait = 0;
            end else begin
                if (aw_hold && (awvalid !== 1'b1 || awaddr !== h_awaddr)) proto_viol++;
                if (w_hold && (wvalid !== 1'b1 || wdata !== h_wdata || wstrb !== h_wstrb)) proto_viol++;
                if (ar_hold && (arvalid !== 1'b1 || araddr !== h_araddr)) proto_viol++;
                aw_hold = awvalid && !awready; h_awaddr = awaddr;
                w_hold  = wvalid && !wready;   h_wdata = wdata; h_wstrb = wstrb;
                ar_hold = arvalid && !arready; h_araddr = araddr;
                if (awvalid) aw_cyc++;
                if (wvalid) w_cyc++;
                if (arvalid) ar_cyc++;
                if (rready) rready_cyc++;
                if (bvalid && bready) begin b_hs++; b_pend = 0; end
                else if (b_pend) b_wait++;
                if (rvalid && rready) begin r_hs++; r_pend = 0; end
                else if (r_pend) r_wait++;
                if (awvalid && awready) begin
                    aw_hs++; aw_got = 1; aw_wait = 0;
                    cap_awaddr = awaddr; cap_awsize = awsize; cap_awlen = awlen;
                    cap_awburst = awburst; cap_awid = awid;
                end else if (awvalid) aw_wait++;
                if (wvalid && wready) begin
                    w_hs++; w_got = 1; w_wait = 0;
                    cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
                end else if (wvalid) w_wait++;
                if (arvalid && arready) begin
                    ar_hs++; ar_wait = 0; r_pend = 1; r_wait = 0;
                    cap_araddr = araddr; cap_arsize = arsize; cap_arlen = arlen;
                    cap_arburst = arburst; cap_arid = arid;
                end else if (arvalid) ar_wait++;
                if (aw_got && w_got) begin
                    for (int i = 0; i < 8; i++)
                        if (cap_wstrb[i]) smem[int'({cap_awaddr[11:3], 3'b000}) + i] = cap_wdata[8*i +: 8];
                    aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
                end
            end
            @(negedge clk);
            awready = awvalid && (aw_wait >= aw_delay);
            wready  = wvalid && (w_wait >= w_delay);
            arready = arvalid && (ar_wait >= ar_delay);
            bvalid  = b_pend && (b_wait >= b_delay);
            bid = bid_cfg; bresp = bresp_cfg;
            rvalid  = r_pend && (r_wait >= r_delay);
            rid = rid_cfg; rresp = rresp_cfg; rlast = rlast_cfg;
            for (int i = 0; i < 8; i++) rdata[8*i +: 8] = smem[int'({cap_araddr[11:3], 3'b000}) + i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_read(input logic [31:0] a, input int w);
        logic [63:0] v = '0;
        for (int i = 0; i < (1 << w); i++) v[8*i +: 8] = rmem[int'(a[11:0]) + i];
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input int w, input logic [63:0] d);
        for (int i = 0; i < (1 << w); i++) rmem[int'(a[11:0]) + i] = d[8*i +: 8];
    endtask

    // Caller must be at a negedge; returns at the negedge of the response cycle (plus one when rejected).
    task automatic do_req(input bit cmd, input int w, input logic [31:0] a, input logic [63:0] d,
                          output int lat, output logic err, output logic [63:0] rd);
        core_req = 1; core_cmd = cmd; core_width = 2'(w); core_addr = a; core_wdata = d;
        #1;
        check("ack", {63'd0, core_ack}, 64'd1);
        @(negedge clk);
        core_req = 0; core_width = 2'($urandom); core_addr = $urandom; core_wdata = {$urandom, $urandom};
        lat = 1;
        while (core_resp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("resp_timeout", {63'd0, lat < 100}, 64'd1);
        err = core_resp_err;
        rd  = core_rdata;
        if (lat == 1) @(negedge clk);
    endtask

    int          lat, a0, b0, c0, d0;
    logic        err;
    logic [63:0] rd, d;
    logic [31:0] a;
    int          w, xlat;
    bit          cmd, bad, saw_resp;
    logic        xerr;
    logic [7:0]  xstrb;

    initial begin
        rst = 1; core_req = 0; core_cmd = 0; core_width = 0; core_addr = '0; core_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            rmem[i] = 8'($urandom);
            smem[i] = rmem[i];
        end
        for (int i = 0; i < 8; i++) begin
            rmem[256 + i] = 8'(8'h11 * (i + 1));
            smem[256 + i] = rmem[256 + i];
        end
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_awvalid", {63'd0, awvalid}, 64'd0);
        check("rst_wvalid", {63'd0, wvalid}, 64'd0);
        check("rst_arvalid", {63'd0, arvalid}, 64'd0);
        check("rst_bready", {63'd0, bready}, 64'd0);
        check("rst_rready", {63'd0, rready}, 64'd0);
        check("rst_resp_valid", {63'd0, core_resp_valid}, 64'd0);
        check("rst_resp_err", {63'd0, core_resp_err}, 64'd0);
        check("rst_rdata", core_rdata, 64'd0);
        @(negedge clk);

        // word write at 0x104
        do_req(1, 2, 32'h104, 64'hDEADBEEF, lat, err, rd);
        ref_write(32'h104, 2, 64'hDEADBEEF);
        check("w1_lat", 64'(lat), 64'd3);
        check("w1_err", {63'd0, err}, 64'd0);
        check("w1_awaddr", 64'(cap_awaddr), 64'h104);
        check("w1_awsize", 64'(cap_awsize), 64'd2);
        check("w1_wstrb", 64'(cap_wstrb), 64'hF0);
        check("w1_wdata_hi", 64'(cap_wdata[63:32]), 64'hDEADBEEF);
        check("w1_awlen", 64'(cap_awlen), 64'd0);
        check("w1_awburst", 64'(cap_awburst), 64'd1);
        check("w1_wlast", {63'd0, cap_wlast}, 64'd1);
        check("w1_awid", 64'(cap_awid), 64'd0);

        // byte read at 0x103
        do_req(0, 0, 32'h103, 64'd0, lat, err, rd);
        exp_rdata = 64'h44;
        check("r1_lat", 64'(lat), 64'd3);
        check("r1_err", {63'd0, err}, 64'd0);
        check("r1_rdata", rd, exp_rdata);
        check("r1_arsize", 64'(cap_arsize), 64'd0);
        check("r1_araddr", 64'(cap_araddr), 64'h103);
        check("r1_arlen", 64'(cap_arlen), 64'd0);
        check("r1_arburst", 64'(cap_arburst), 64'd1);
        check("r1_arid", 64'(cap_arid), 64'd0);

        // write with AW stalled 4 cycles
        aw_delay = 4;
        a0 = aw_cyc; b0 = w_cyc; c0 = b_hs;
        d = {$urandom, $urandom};
        do_req(1, 3, 32'h208, d, lat, err, rd);
        ref_write(32'h208, 3, d);
        aw_delay = 0;
        check("w2_lat", 64'(lat), 64'd7);
        check("w2_err", {63'd0, err}, 64'd0);
        check("w2_aw_cycles", 64'(aw_cyc - a0), 64'd5);
        check("w2_w_cycles", 64'(w_cyc - b0), 64'd1);
        check("w2_b_handshakes", 64'(b_hs - c0), 64'd1);
        check("w2_rdata_kept", rd, exp_rdata);
        check("w2_proto", 64'(proto_viol), 64'd0);

        // misaligned half read
        a0 = ar_cyc; b0 = aw_cyc;
        do_req(0, 1, 32'h201, 64'd0, lat, err, rd);
        check("e1_lat", 64'(lat), 64'd1);
        check("e1_err", {63'd0, err}, 64'd1);
        check("e1_no_ar", 64'(ar_cyc - a0), 64'd0);
        check("e1_no_aw", 64'(aw_cyc - b0), 64'd0);
        check("e1_rdata_kept", rd, exp_rdata);

        // read with SLVERR and delayed R
        rresp_cfg = 2'b10; r_delay = 5;
        a0 = rready_cyc;
        do_req(0, 2, 32'h200, 64'd0, lat, err, rd);
        exp_rdata = ref_read(32'h200, 2);
        rresp_cfg = 2'b00; r_delay = 0;
        check("r2_lat", 64'(lat), 64'd8);
        check("r2_err", {63'd0, err}, 64'd1);
        check("r2_rready_cycles", 64'(rready_cyc - a0), 64'd6);
        check("r2_rdata", rd, exp_rdata);

        // back-to-back: acked in the previous response cycle
        do_req(0, 3, 32'h208, 64'd0, lat, err, rd);
        exp_rdata = ref_read(32'h208, 3);
        check("r3_lat", 64'(lat), 64'd3);
        check("r3_err", {63'd0, err}, 64'd0);
        check("r3_rdata", rd, exp_rdata);

        // reset while waiting in the write-address phase
        aw_delay = 10; w_delay = 10;
        core_req = 1; core_cmd = 1; core_width = 2'd2; core_addr = 32'h300; core_wdata = 64'h1234;
        #1;
        check("rst2_ack", {63'd0, core_ack}, 64'd1);
        @(negedge clk);
        core_req = 0;
        check("rst2_awvalid_pre", {63'd0, awvalid}, 64'd1);
        check("rst2_wvalid_pre", {63'd0, wvalid}, 64'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        saw_resp = 0;
        check("rst2_awvalid", {63'd0, awvalid}, 64'd0);
        check("rst2_wvalid", {63'd0, wvalid}, 64'd0);
        check("rst2_arvalid", {63'd0, arvalid}, 64'd0);
        check("rst2_bready", {63'd0, bready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (core_resp_valid !== 1'b0) saw_resp = 1;
            @(negedge clk);
        end
        check("rst2_no_resp", {63'd0, saw_resp}, 64'd0);
        aw_delay = 0; w_delay = 0;
        do_req(0, 3, 32'h100, 64'd0, lat, err, rd);
        exp_rdata = ref_read(32'h100, 3);
        check("rst2_read_lat", 64'(lat), 64'd3);
        check("rst2_read_err", {63'd0, err}, 64'd0);
        check("rst2_read_data", rd, exp_rdata);

        // randomized transactions against the memory model
        for (int n = 0; n < 60; n++) begin
            cmd = 1'($urandom);
            w   = int'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << w) - 32'd1);
            if (a > 32'd4088) a = 32'd4088;
            d   = {$urandom, $urandom};
            bad = (a % (32'd1 << w)) != 32'd0;
            aw_delay = int'($urandom_range(0, 3)); w_delay = int'($urandom_range(0, 3));
            ar_delay = int'($urandom_range(0, 3)); r_delay = int'($urandom_range(0, 3));
            b_delay  = int'($urandom_range(0, 3));
            rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rid_cfg   = ($urandom_range(0, 7) == 0) ? 4'd3 : 4'd0;
            bid_cfg   = ($urandom_range(0, 7) == 0) ? 4'd5 : 4'd0;
            rlast_cfg = ($urandom_range(0, 7) != 0);
            a0 = ar_cyc; b0 = aw_cyc; d0 = w_cyc;
            do_req(cmd, w, a, d, lat, err, rd);
            if (bad) begin
                check("rnd_bad_lat", 64'(lat), 64'd1);
                check("rnd_bad_err", {63'd0, err}, 64'd1);
                check("rnd_bad_quiet", 64'((ar_cyc - a0) + (aw_cyc - b0) + (w_cyc - d0)), 64'd0);
                check("rnd_bad_rdata", rd, exp_rdata);
            end else if (!cmd) begin
                xlat = 3 + ar_delay + r_delay;
                xerr = (rresp_cfg != 2'b00) || (rid_cfg != 4'd0) || !rlast_cfg;
                exp_rdata = ref_read(a, w);
                check("rnd_rd_lat", 64'(lat), 64'(xlat));
                check("rnd_rd_err", {63'd0, err}, {63'd0, xerr});
                check("rnd_rd_data", rd, exp_rdata);
                check("rnd_rd_addr", 64'(cap_araddr), 64'(a));
                check("rnd_rd_size", 64'(cap_arsize), 64'(w));
            end else begin
                xlat  = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
                xerr  = (bresp_cfg != 2'b00) || (bid_cfg != 4'd0);
                xstrb = 8'(((1 << (1 << w)) - 1) << a[2:0]);
                ref_write(a, w, d);
                check("rnd_wr_lat", 64'(lat), 64'(xlat));
                check("rnd_wr_err", {63'd0, err}, {63'd0, xerr});
                check("rnd_wr_addr", 64'(cap_awaddr), 64'(a));
                check("rnd_wr_size", 64'(cap_awsize), 64'(w));
                check("rnd_wr_strb", 64'(cap_wstrb), 64'(xstrb));
                check("rnd_wr_rdata_kept", rd, exp_rdata);
            end
        end
        check("final_proto", 64'(proto_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scr1_axi_master_bridge.md
Name: scr1_axi_master_bridge

Overview:
Single-outstanding AXI4 initiator that converts the simple core memory request port into single-beat AXI read or write transactions. It is the master end that drives one memory interface of the AXI testbench memory and of AXI slaves in the SoC. Accepted bursts are single-beat only: len=0, INCR.

Parameters:
W_ID, 4, AXI ID width.
W_ADR, 32, address width.
W_DATA, 64, AXI data width in bits; must be 32 or 64.
AXI_ID, 0, constant ID driven on awid/arid.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
core_req  in  1  request valid.
core_cmd  in  1  0 = read, 1 = write.
core_width  in  2  access size as log2(bytes): 0 = byte, 1 = half, 2 = word, 3 = dword.
core_addr  in  W_ADR  byte address.
core_wdata  in  W_DATA  write data, right-justified.
core_ack  out  1  request accepted.
core_resp_valid  out  1  one-cycle completion pulse.
core_resp_err  out  1  error flag, qualified by core_resp_valid.
core_rdata  out  W_DATA  read data, right-justified and zero-extended.
awvalid/awid/awaddr/awsize/awlen/awburst/awready  out/out/out/out/out/out/in  1/W_ID/W_ADR/3/8/2/1  AXI AW channel.
wvalid/wdata/wstrb/wlast/wready  out/out/out/out/in  1/W_DATA/W_DATA/8/1/1  AXI W channel.
bvalid/bid/bresp/bready  in/in/in/out  1/W_ID/2/1  AXI B channel.
arvalid/arid/araddr/arsize/arlen/arburst/arready  out/out/out/out/out/out/in  1/W_ID/W_ADR/3/8/2/1  AXI AR channel.
rvalid/rid/rdata/rlast/rresp/rready  in/in/in/in/in/out  1/W_ID/W_DATA/1/2/1  AXI R channel.

Behaviour:
- Reset values: all valid and ready outputs 0, core_resp_valid 0, core_resp_err 0, core_rdata 0, FSM in IDLE. Reset asserted mid-transaction aborts it immediately with no response.
- Constant outputs: awlen/arlen = 0, awburst/arburst = 2'b01, wlast = 1, awid/arid = AXI_ID.
- core_ack = core_req & (state == IDLE), combinational. On ack, cmd, width, addr and wdata are latched.
- FSM states and transitions:
  - IDLE: accepts a request and moves to RD_A, WR_AW, or ERR.
  - RD_A: arvalid = 1 and stays asserted with stable payload until arready. Moves to RD_R.
  - RD_R: rready = 1. On rvalid, moves to IDLE with core_resp_valid pulsed in the next cycle.
  - WR_AW: awvalid and wvalid are both asserted in the first cycle and each is held until its own handshake. Handshakes tracked by aw_done/w_done flags; completion order is free and may be simultaneous. When both are done, moves to WR_B.
  - WR_B: bready = 1. On bvalid, moves to IDLE with core_resp_valid pulsed next cycle.
  - ERR: no AXI activity. core_resp_valid = 1 and err = 1 in this cycle, then IDLE.
- ERR entry condition: addr not aligned to 2**width, or 2**width > W_DATA/8.
- Lane arithmetic: lane = addr[log2(W_DATA/8)-1:0].
  - wdata = core_wdata << 8*lane.
  - wstrb = ((1 << 2**width) - 1) << lane.
  - awaddr/araddr = full unaligned-free addr; awsize/arsize = width.
- Read data: core_rdata = (rdata >> 8*lane) masked to 2**width bytes, zero-extended.
- Read error: core_resp_err = (rresp != 0) | (rid != AXI_ID) | ~rlast.
- Write error: core_resp_err = (bresp != 0) | (bid != AXI_ID).
- core_rdata holds its value until the next read completes. It is not changed by writes.
- Latency with always-ready slave: ack at cycle 0, ar/aw valid at cycle 1; with slave response at cycle 2, core_resp_valid at cycle 3.
- Minimum request issue interval is 3 cycles: ack is possible in the same cycle as the previous core_resp_valid.
- Only one transaction is outstanding at any time. AXI valid signals never drop before their handshake.

Decomposition:
- Shared package scr1_axi_pkg holds:
  - the FSM state enum;
  - AXI_RESP_OKAY/SLVERR/DECERR constants;
  - AXI_BURST_INCR;
  - a core-width enum.
- One sub-module, scr1_axi_lane_align: combinational wstrb/wdata shift and rdata extract/mask, reused by the read and write paths.

Test Plan:
- Word write addr 0x104, wdata 0xDEADBEEF, ready-always slave -> awaddr 0x104, awsize 2, wstrb 0xF0, wdata[63:32] = 0xDEADBEEF; resp_valid at cycle 3, err 0.
- Byte read addr 0x103, memory dword at 0x100 = 0x8877665544332211 -> arsize 0, core_rdata = 0x44, err 0.
- Write with awready held low 4 cycles and wready immediate -> wvalid drops after its handshake, awvalid held stable; resp follows the B handshake; exactly one bready handshake.
- Half read at odd addr 0x201 -> no arvalid ever asserted; core_resp_valid at cycle 1 with err 1.
- Read returning rresp = 2'b10, with rvalid delayed 5 cycles -> rready held 1 throughout; err 1; the following request is acked in the resp cycle.
- rst pulsed while in WR_AW -> next cycle all valids 0, state IDLE, no core_resp_valid; a subsequent read completes normally.
